// File: rtl/vpipe_fetch_issue.sv
// vpipe_fetch_issue: instruction fetch front-end for a small processor.
// Fetches 6-bit instructions from an instruction memory with a fixed
// one-cycle response latency, buffers them in a 4-entry FIFO and presents
// the FIFO head to the processor.
//
// Optional feature macro: VPIPE_FETCH_PERF_EN adds the saturating
// perf_issued / perf_stall counters and their output ports.
//
// Handshake: the head instruction transfers on a cycle where
// issue_valid && issue_ready are both 1; issue_valid never depends on
// issue_ready, and the head stays stable until it is popped or a redirect
// flushes the queue.
module vpipe_fetch_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_pc,
  input  logic       halt,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_rsp_valid,
  input  logic [5:0] imem_rsp_data,
  output logic       issue_valid,
  input  logic       issue_ready,
  output logic [1:0] op,
  output logic [1:0] operand1,
  output logic [1:0] operand2,
  output logic       busy
`ifdef VPIPE_FETCH_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [2:0]  r_count;
  logic [1:0]  r_head;
  logic [1:0]  r_tail;
  logic        r_inflight;
  logic [5:0]  r_mem [4];

  logic        w_redir;
  logic        w_push;
  logic        w_pop;
  logic [5:0]  w_head_data;
  logic [2:0]  w_occupancy;

  // A redirect only takes effect where fetching can be under way.
  assign w_redir     = redirect && ((r_state == S_RUN) || (r_state == S_DRAIN));
  // Responses landing in the REDIRECT cycle belong to the old stream.
  assign w_push      = imem_rsp_valid && r_inflight && (r_state != S_REDIRECT);
  assign w_pop       = issue_valid && issue_ready;
  assign w_head_data = r_mem[r_head];
  assign w_occupancy = r_count + {2'b00, r_inflight};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; redirect outranks halt in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (redirect)  w_state_nxt = S_REDIRECT;
        else if (halt) w_state_nxt = S_DRAIN;
      end
      S_REDIRECT: w_state_nxt = S_RUN;
      S_DRAIN: begin
        if (redirect)                             w_state_nxt = S_REDIRECT;
        else if ((r_count == 3'd0) && !r_inflight) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-driven outputs: request only while queue plus in-flight slot has room.
  always_comb begin
    imem_req  = (r_state == S_RUN) && (w_occupancy < 3'd4);
    imem_addr = r_pc;
    busy      = (r_state != S_IDLE);
  end

  // Issue outputs: a proc no-op whenever the queue is empty.
  always_comb begin
    issue_valid = (r_count != 3'd0);
    op          = 2'b11;
    operand1    = 2'b00;
    operand2    = 2'b00;
    if (issue_valid) begin
      op       = w_head_data[5:4];
      operand1 = w_head_data[3:2];
      operand2 = w_head_data[1:0];
    end
  end

  // Fetch pointer: redirect/start load it, each request advances it (wraps at 256).
  always_ff @(posedge clk) begin
    if (rst)                             r_pc <= 8'd0;
    else if (w_redir)                    r_pc <= redirect_pc;
    else if ((r_state == S_IDLE) && start) r_pc <= start_pc;
    else if (imem_req)                   r_pc <= r_pc + 8'd1;
  end

  // In-flight flag: the request issued last cycle expects a response now.
  always_ff @(posedge clk) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= imem_req;
  end

  // Queue pointers and count; a redirect flushes everything in the same edge.
  always_ff @(posedge clk) begin
    if (rst || w_redir) begin
      r_count <= 3'd0;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
    end else begin
      if (w_push) r_tail <= r_tail + 2'd1;
      if (w_pop)  r_head <= r_head + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && !w_redir && w_push) r_mem[r_tail] <= imem_rsp_data;
  end

`ifdef VPIPE_FETCH_PERF_EN
  // Saturating counters of issued instructions and starved RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= 16'd0;
      perf_stall  <= 16'd0;
    end else begin
      if (w_pop && (perf_issued != 16'hFFFF)) perf_issued <= perf_issued + 16'd1;
      if ((r_state == S_RUN) && !issue_valid && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

  // Request throttling keeps the queue from ever overfilling.
  a_count_max: assert property (@(posedge clk) disable iff (rst) r_count <= 3'd4);

endmodule

// File: tb/tb_vpipe_fetch_issue.sv
// Bench for vpipe_fetch_issue: directed scenarios followed by a random
// phase, all checked every cycle against a queue-based reference model.
module tb_vpipe_fetch_issue;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_REDIR = 2;
  localparam int M_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_pc = 8'd0;
  logic       halt = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'd0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rsp_valid = 1'b0;
  logic [5:0] imem_rsp_data = 6'd0;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [1:0] op;
  logic [1:0] operand1;
  logic [1:0] operand2;
  logic       busy;
`ifdef VPIPE_FETCH_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  vpipe_fetch_issue dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .halt           (halt),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .op             (op),
    .operand1       (operand1),
    .operand2       (operand2),
    .busy           (busy)
`ifdef VPIPE_FETCH_PERF_EN
    ,
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  int         m_mode = M_IDLE;
  logic [7:0] m_pc = 8'd0;
  logic       m_infl = 1'b0;
  logic [5:0] exp_q[$];
  int         m_iss = 0;
  int         m_stall = 0;

  logic [5:0] imem_mem [256];
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'd0;
  logic       force_rsp = 1'b0;
  logic [7:0] addr_log[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, driven by the inputs applied this cycle.
  task automatic model_edge(input logic e_req, input logic e_valid);
    int  size0;
    logic infl0;
    int  mode0;
    if (rst) begin
      m_mode = M_IDLE; m_pc = 8'd0; m_infl = 1'b0; exp_q.delete();
      m_iss = 0; m_stall = 0;
      return;
    end
    if (e_valid && issue_ready && m_iss < 65535) m_iss++;
    if (m_mode == M_RUN && !e_valid && m_stall < 65535) m_stall++;
    size0 = exp_q.size();
    infl0 = m_infl;
    mode0 = m_mode;
    m_infl = e_req;
    if (redirect && (mode0 == M_RUN || mode0 == M_DRAIN)) begin
      exp_q.delete();
      m_pc = redirect_pc;
      m_mode = M_REDIR;
      return;
    end
    if (e_valid && issue_ready) void'(exp_q.pop_front());
    if (imem_rsp_valid && infl0 && mode0 != M_REDIR) exp_q.push_back(imem_rsp_data);
    if (e_req) m_pc = m_pc + 8'd1;
    case (mode0)
      M_IDLE:  if (start) begin m_mode = M_RUN; m_pc = start_pc; end
      M_RUN:   if (halt) m_mode = M_DRAIN;
      M_REDIR: m_mode = M_RUN;
      default: if (size0 == 0 && !infl0) m_mode = M_IDLE;
    endcase
  endtask

  // ---------------- driver: one cycle with full output check ----------------
  task automatic step();
    logic       e_req;
    logic       e_valid;
    logic [5:0] e_head;
    imem_rsp_valid = prev_req | force_rsp;
    imem_rsp_data  = imem_mem[prev_addr];
    #1;
    e_req   = (m_mode == M_RUN) && ((exp_q.size() + int'(m_infl)) < 4);
    e_valid = (exp_q.size() != 0);
    e_head  = e_valid ? exp_q[0] : 6'b11_00_00;
    chk("imem_req",    16'(imem_req),    16'(e_req));
    chk("imem_addr",   16'(imem_addr),   16'(m_pc));
    chk("issue_valid", 16'(issue_valid), 16'(e_valid));
    chk("op",          16'(op),          16'(e_head[5:4]));
    chk("operand1",    16'(operand1),    16'(e_head[3:2]));
    chk("operand2",    16'(operand2),    16'(e_head[1:0]));
    chk("busy",        16'(busy),        16'(m_mode != M_IDLE));
`ifdef VPIPE_FETCH_PERF_EN
    chk("perf_issued", perf_issued, 16'(m_iss));
    chk("perf_stall",  perf_stall,  16'(m_stall));
`endif
    if (imem_req) addr_log.push_back(imem_addr);
    model_edge(e_req, e_valid);
    prev_req  = imem_req;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
    start = 1'b0; halt = 1'b0; redirect = 1'b0; force_rsp = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    issue_ready = 1'b1;
    for (int k = 0; k < 30 && busy !== 1'b0; k++) step();
    chk(tag, 16'(busy), 16'd0);
  endtask

  task automatic drain(input string tag);
    halt = 1'b1;
    step();
    wait_idle(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int a = 0; a < 256; a++) imem_mem[a] = 6'($urandom_range(0, 63));
    imem_mem[8'h10] = 6'b10_01_10;

    // Reset; then a stray response right after reset must be dropped.
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    force_rsp = 1'b1;
    step();
    chk("rst_stray_rsp_dropped", 16'(issue_valid), 16'd0);
    chk("rst_op_noop", 16'(op), 16'd3);
`ifdef VPIPE_FETCH_PERF_EN
    chk("rst_perf_issued", perf_issued, 16'd0);
`endif

    // Start at 0x10: request in cycle 1, instruction issues in cycle 3.
    issue_ready = 1'b1;
    start = 1'b1; start_pc = 8'h10;
    step();
    chk("a_req_c1",  16'(imem_req),  16'd1);
    chk("a_addr_c1", 16'(imem_addr), 16'h10);
    step();
    step();
    chk("a_valid_c3", 16'(issue_valid), 16'd1);
    chk("a_op_c3",    16'(op),          16'd2);
    chk("a_opnd1_c3", 16'(operand1),    16'd1);
    chk("a_opnd2_c3", 16'(operand2),    16'd2);
    drain("a_idle");

    // Backpressure: queue fills, requests stop at start_pc+4, then resume.
    issue_ready = 1'b0;
    start = 1'b1; start_pc = 8'h20;
    step();
    for (int k = 0; k < 8; k++) step();
    chk("b_full_valid", 16'(issue_valid), 16'd1);
    chk("b_req_off",    16'(imem_req),    16'd0);
    chk("b_pc_stop",    16'(imem_addr),   16'h24);
    issue_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    drain("b_idle");

    // pc wrap-around from 0xFE.
    start = 1'b1; start_pc = 8'hFE;
    step();
    addr_log.delete();
    for (int k = 0; k < 5; k++) step();
    chk("c_nreq", 16'(addr_log.size() >= 4), 16'd1);
    chk("c_addr0", 16'(addr_log[0]), 16'hFE);
    chk("c_addr1", 16'(addr_log[1]), 16'hFF);
    chk("c_addr2", 16'(addr_log[2]), 16'h00);
    chk("c_addr3", 16'(addr_log[3]), 16'h01);
    drain("c_idle");

    // Redirect with three queued and one in flight.
    issue_ready = 1'b0;
    start = 1'b1; start_pc = 8'h30;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("d_pre_valid", 16'(issue_valid), 16'd1);
    chk("d_pre_req",   16'(imem_req),    16'd0);
    redirect = 1'b1; redirect_pc = 8'h40; halt = 1'b1;
    step();
    chk("d_flush_valid", 16'(issue_valid), 16'd0);
    chk("d_flush_op",    16'(op),          16'd3);
    chk("d_flush_req",   16'(imem_req),    16'd0);
    step();
    chk("d_req_new", 16'(imem_req),  16'd1);
    chk("d_addr_new", 16'(imem_addr), 16'h40);
    issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    drain("d_idle");

    // Halt with two queued: drain them without new requests.
    issue_ready = 1'b0;
    start = 1'b1; start_pc = 8'h50;
    step();
    for (int k = 0; k < 3; k++) step();
    issue_ready = 1'b1; halt = 1'b1;
    step();
    chk("e_no_req_after_halt", 16'(imem_req), 16'd0);
    wait_idle("e_idle");

    // Control inputs outside their legal states are ignored.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h77;
    step();
    chk("f_idle_ignore", 16'(busy), 16'd0);

    // Random phase.
    for (int i = 0; i < 700; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 7) == 0);
      start_pc    = 8'($urandom_range(0, 255));
      halt        = ($urandom_range(0, 29) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      issue_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    // Final reset clears everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("z_busy", 16'(busy), 16'd0);
`ifdef VPIPE_FETCH_PERF_EN
    chk("z_perf_issued", perf_issued, 16'd0);
    chk("z_perf_stall",  perf_stall,  16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vpipe_fetch_issue.md
VPIPE_FETCH_ISSUE -- requirements
Module: vpipe_fetch_issue

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- start  in  1  begin fetching at start_pc (pulse)
- start_pc  in  8  first fetch address
- halt  in  1  stop fetching, drain queue (pulse)
- redirect  in  1  discard queued and in-flight instructions, refetch from redirect_pc (pulse)
- redirect_pc  in  8  new fetch address
- imem_req  out  1  fetch request
- imem_addr  out  8  fetch address
- imem_rsp_valid  in  1  response valid, exactly 1 cycle after imem_req
- imem_rsp_data  in  6  instruction {op[5:4], operand1[3:2], operand2[1:0]}
- issue_valid  out  1  head instruction valid
- issue_ready  in  1  proc consumes head this cycle
- op  out  2  opcode to proc
- operand1  out  2  destination or address register
- operand2  out  2  source register
- busy  out  1  state != IDLE

Function
REQ-002 The FSM SHALL have states IDLE, RUN, REDIRECT and DRAIN.
REQ-003 Transitions SHALL be:
- IDLE->RUN on start, with pc<=start_pc.
- RUN->REDIRECT on redirect.
- RUN->DRAIN on halt.
- REDIRECT->RUN after exactly 1 cycle.
- DRAIN->IDLE when the queue is empty and no request is in flight.
- DRAIN->REDIRECT on redirect.
REQ-004 start SHALL be ignored outside IDLE; halt SHALL be ignored outside RUN; redirect SHALL be ignored in IDLE.
REQ-005 If redirect and halt are both asserted in RUN, redirect SHALL win.
REQ-006 The block SHALL contain a 4-entry FIFO of 6-bit instructions with a 3-bit count (0..4).
REQ-007 In RUN, imem_req SHALL be 1 iff count + inflight < 4, where inflight is the registered imem_req of the previous cycle.
REQ-008 imem_addr SHALL equal pc; pc SHALL increment by 1 modulo 256 on every cycle with imem_req=1 (pc 255 wraps to 0).
REQ-009 imem_req SHALL be 0 in IDLE, REDIRECT and DRAIN.
REQ-010 imem_rsp_valid with a non-discarded in-flight request SHALL push imem_rsp_data at the FIFO tail at the end of that cycle.
REQ-011 issue_valid SHALL equal (count != 0); {op, operand1, operand2} SHALL be driven combinationally from the FIFO head.
REQ-012 issue_valid & issue_ready SHALL pop the head.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged and SHALL be legal at count 4 and at count 0 (no bypass: the pushed entry issues next cycle).
REQ-014 When issue_valid=0, op SHALL be 2'b11 (proc no-op) and operand1 and operand2 SHALL be 0, so the proc never sees a spurious ALU op, STORE or LOAD.
REQ-015 On entering REDIRECT:
- count, head and tail SHALL clear in the same edge that latches pc<=redirect_pc.
- A response arriving during the REDIRECT cycle SHALL be discarded.
- A pop requested in the redirect cycle SHALL have no effect beyond the clear.
REQ-016 The first request after redirect SHALL be issued in the first RUN cycle with imem_addr=redirect_pc.
REQ-017 Overflow and underflow SHALL be impossible by construction; the design SHALL contain an assertion that count never exceeds 4.

Reset
REQ-018 On rst the block SHALL set:
- state=IDLE, pc=0, count=0, head=tail=0, inflight=0
- imem_req=0, issue_valid=0, op=2'b11, operand1=0, operand2=0, busy=0
REQ-019 rst SHALL take priority over all other inputs; an in-flight response arriving in the cycle after rst SHALL be discarded.
REQ-020 FIFO storage SHALL NOT require reset.

Configuration
REQ-021 With VPIPE_FETCH_PERF_EN defined, the block SHALL add outputs:
- perf_issued[15:0]: counts cycles with issue_valid & issue_ready.
- perf_stall[15:0]: counts cycles in RUN with issue_valid=0.
- Both counters saturate at 16'hFFFF and clear on rst.
REQ-022 Without VPIPE_FETCH_PERF_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 Reset, start with start_pc=8'h10, imem responds 6'b10_01_10, issue_ready=1 -> imem_req in cycle 1 with addr 8'h10; issue_valid in cycle 3 with op=2, operand1=1, operand2=2.
REQ-024 issue_ready=0 in RUN -> count reaches 4, imem_req deasserts with pc=start_pc+4; raise issue_ready -> one pop per cycle and requests resume with no lost or duplicated instruction.
REQ-025 start_pc=8'hFE, free-run -> fetch addresses FE, FF, 00, 01 in order.
REQ-026 Redirect to 8'h40 while count=3 and a request is in flight -> next cycle issue_valid=0, op=3; the in-flight response is dropped; the next request addresses 8'h40.
REQ-027 halt with count=2, issue_ready=1 -> no further imem_req; two issues; then state IDLE and busy=0.
REQ-028 With VPIPE_FETCH_PERF_EN, run 5 issues and 3 starved RUN cycles -> perf_issued=5, perf_stall=3; assert rst -> both 0.
